lut_decoder_pipe: RTL



---
 rtl/lut_decoder_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/lut_decoder_pipe.sv
// ============================================================================
// lut_decoder_pipe : registered, run-time-writable lookup decoder, valid/ready
// Optional lookup counter enabled by LUT_DECODER_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module lut_decoder_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_word,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data
`ifdef LUT_DECODER_CNT_EN
  ,
  output logic [15:0]      lookup_cnt
`endif
);

  localparam int DEPTH = 1 << IN_W;

  // Seed values are 4 bits wide; widen first so any OUT_W slices cleanly.
  function automatic logic [OUT_W-1:0] reset_entry(input int idx);
    logic [OUT_W+3:0] v;
    v = '0;
    case (idx)
      0:       v[3:0] = 4'h4;
      1:       v[3:0] = 4'hA;
      2:       v[3:0] = 4'h7;
      3:       v[3:0] = 4'hC;
      4:       v[3:0] = 4'h9;
      5:       v[3:0] = 4'hD;
      6:       v[3:0] = 4'h0;
      7:       v[3:0] = 4'h2;
      default: v[3:0] = 4'h0;
    endcase
    return v[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] lut_q [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_word_q, out_word_d;
  logic             accept;
  logic             xfer;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_word_d  = lut_q[in_code];
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  // Lookup above reads the pre-edge entry, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= reset_entry(i);
    end else if (wr_en) begin
      lut_q[wr_addr] <= wr_data;
    end
  end

`ifdef LUT_DECODER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lookup_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
